// File: rtl/xb_seq_ctrl.sv
// xb_seq_ctrl: sequencing controller for the high-pass wavelet filter bank.
// Owns the eight coefficient registers, pulls one frame of FRAME_LEN samples
// from upstream, strobes them into the bank, and forwards the FRAME_LEN/2
// decimated outputs. Completion is a one-cycle done pulse plus a sticky bit.
// Optional: define XB_CTRL_TIMEOUT_EN to bound the DRAIN wait by DRAIN_TIMEOUT
// cycles (sticky timeout_err in status bit 3).
module xb_seq_ctrl #(
    parameter int FRAME_LEN     = 64,
    parameter int DRAIN_TIMEOUT = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cfg_we,
    input  logic [3:0]  cfg_addr,
    input  logic [15:0] cfg_wdata,
    output logic [15:0] cfg_rdata,
    input  logic        src_valid,
    input  logic [15:0] src_data,
    output logic        src_ready,
    output logic [15:0] fb_data,
    output logic        fb_data_read,
    input  logic        fb_ready,
    input  logic [15:0] fb_dout,
    output logic        out_valid,
    output logic [15:0] out_data,
    output logic [15:0] coef0,
    output logic [15:0] coef1,
    output logic [15:0] coef2,
    output logic [15:0] coef3,
    output logic [15:0] coef4,
    output logic [15:0] coef5,
    output logic [15:0] coef6,
    output logic [15:0] coef7,
    output logic        done,
    output logic        busy
);

    localparam int              CW   = $clog2(FRAME_LEN) + 1;
    localparam logic [CW-1:0]   LAST = CW'(FRAME_LEN - 1);
    localparam logic [CW-1:0]   HALF = CW'(FRAME_LEN / 2);
    localparam int              TW   = $clog2(DRAIN_TIMEOUT + 1);
    localparam logic [TW-1:0]   TMO_LAST = TW'(DRAIN_TIMEOUT - 1);
`ifdef XB_CTRL_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, FINISH} state_t;

    state_t          state_q;
    logic [CW-1:0]   in_cnt_q;
    logic [CW-1:0]   out_cnt_q;
    logic [TW-1:0]   tmo_cnt_q;
    logic [15:0]     coef_q [8];
    logic            lock_err_q;
    logic            done_sticky_q;
    logic            timeout_err_q;
    logic            busy_q;
    logic            done_q;
    logic            fb_data_read_q;
    logic [15:0]     fb_data_q;
    logic            out_valid_q;
    logic [15:0]     out_data_q;

    logic ctrl_wr, start, abort, clr, coef_wr, out_take, tmo_hit;

    assign ctrl_wr = cfg_we && (cfg_addr == 4'd8);
    assign start   = ctrl_wr && cfg_wdata[0];
    assign abort   = ctrl_wr && cfg_wdata[1];
    assign clr     = ctrl_wr && cfg_wdata[2];
    assign coef_wr = cfg_we && !cfg_addr[3];

    // Accept a sample only while in RUN and the frame is not yet full.
    assign src_ready = (state_q == RUN) && src_valid && (in_cnt_q < CW'(FRAME_LEN));

    // Bank outputs count only while a frame is active and not yet complete.
    assign out_take = fb_ready && ((state_q == RUN) || (state_q == DRAIN))
                      && (out_cnt_q < HALF);

    // Watchdog fires only with no bank output this cycle; a real output wins.
    assign tmo_hit = TMO_EN && (state_q == DRAIN) && !fb_ready && (tmo_cnt_q == TMO_LAST);

    // Control FSM with sticky status, frame counters and done/busy outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            in_cnt_q      <= '0;
            out_cnt_q     <= '0;
            lock_err_q    <= 1'b0;
            done_sticky_q <= 1'b0;
            timeout_err_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (clr) begin
                lock_err_q    <= 1'b0;
                done_sticky_q <= 1'b0;
                timeout_err_q <= 1'b0;
            end
            if (coef_wr && state_q != IDLE) lock_err_q <= 1'b1;
            if (abort) begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: if (start) begin
                        state_q       <= RUN;
                        busy_q        <= 1'b1;
                        in_cnt_q      <= '0;
                        out_cnt_q     <= '0;
                        done_sticky_q <= 1'b0;
                    end
                    RUN: if (src_ready && in_cnt_q == LAST) state_q <= DRAIN;
                    DRAIN: if (out_cnt_q == HALF || tmo_hit) begin
                        state_q       <= FINISH;
                        done_q        <= 1'b1;
                        done_sticky_q <= 1'b1;
                        if (out_cnt_q != HALF) timeout_err_q <= 1'b1;
                    end
                    FINISH: begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                    default: state_q <= IDLE;
                endcase
            end
            if (src_ready) in_cnt_q  <= in_cnt_q + 1'b1;
            if (out_take)  out_cnt_q <= out_cnt_q + 1'b1;
        end
    end

    // Drain watchdog: DRAIN cycles since entry or since the last bank output.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                             tmo_cnt_q <= '0;
        else if (state_q != DRAIN || fb_ready)  tmo_cnt_q <= '0;
        else if (tmo_cnt_q != TMO_LAST)         tmo_cnt_q <= tmo_cnt_q + 1'b1;
    end

    // Coefficient bank: writable only while idle so a frame sees stable taps.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 8; i++) coef_q[i] <= '0;
        end else if (coef_wr && state_q == IDLE) begin
            coef_q[cfg_addr[2:0]] <= cfg_wdata;
        end
    end

    // Registered sample strobe toward the bank and output forwarding path.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fb_data_read_q <= 1'b0;
            fb_data_q      <= '0;
            out_valid_q    <= 1'b0;
            out_data_q     <= '0;
        end else begin
            fb_data_read_q <= src_ready;
            if (src_ready) fb_data_q <= src_data;
            out_valid_q <= out_take;
            if (out_take) out_data_q <= fb_dout;
        end
    end

    // Config read mux; unmapped addresses read as zero.
    always_comb begin
        cfg_rdata = 16'h0000;
        if (!cfg_addr[3]) begin
            cfg_rdata = coef_q[cfg_addr[2:0]];
        end else begin
            case (cfg_addr)
                4'd9:    cfg_rdata = {12'h000, timeout_err_q, lock_err_q, done_sticky_q, busy_q};
                4'd10:   cfg_rdata = 16'(out_cnt_q);
                default: cfg_rdata = 16'h0000;
            endcase
        end
    end

    assign fb_data      = fb_data_q;
    assign fb_data_read = fb_data_read_q;
    assign out_valid    = out_valid_q;
    assign out_data     = out_data_q;
    assign done         = done_q;
    assign busy         = busy_q;
    assign coef0 = coef_q[0];
    assign coef1 = coef_q[1];
    assign coef2 = coef_q[2];
    assign coef3 = coef_q[3];
    assign coef4 = coef_q[4];
    assign coef5 = coef_q[5];
    assign coef6 = coef_q[6];
    assign coef7 = coef_q[7];

endmodule

// File: doc/xb_seq_ctrl.md
Name: xb_seq_ctrl

Overview:
- Controller for the high-pass wavelet filter bank: owns the eight 16-bit coefficient registers, pulls one frame of samples from an upstream source, strobes them into the bank, and counts/forwards the decimated outputs.
- Sits between the processor config bus and the filter bank.
- Signals completion with a one-cycle done pulse and a sticky status bit.

Parameters:
- FRAME_LEN, 64, samples per frame; even, 2..1024.
- DRAIN_TIMEOUT, 32, cycles allowed in DRAIN for missing outputs (used only with XB_CTRL_TIMEOUT_EN).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low.
- cfg_we  in  1  config write strobe.
- cfg_addr  in  4  0-7 coef, 8 ctrl, 9 status, 10 out count.
- cfg_wdata  in  16  write data.
- cfg_rdata  out  16  combinational read data.
- src_valid  in  1  upstream sample available.
- src_data  in  16  upstream sample.
- src_ready  out  1  sample accepted this cycle.
- fb_data  out  16  sample to filter bank, registered.
- fb_data_read  out  1  one-cycle write strobe to filter bank.
- fb_ready  in  1  filter bank output valid pulse.
- fb_dout  in  16  filter bank output sample.
- out_valid  out  1  registered output valid.
- out_data  out  16  registered output sample.
- coef0..coef7  out  16 each  coefficient registers to the bank.
- done  out  1  one-cycle frame-complete pulse.
- busy  out  1  high when FSM not IDLE.

Behaviour:
- Reset: all coefs 0; FSM IDLE; counters 0; src_ready, fb_data_read, out_valid, done, busy 0; fb_data, out_data 0; sticky bits 0.
- Config writes:
  - addr 0-7 update the coef on the next edge, only in IDLE. A write while busy is dropped and sets sticky lock_err.
  - ctrl (addr 8): bit0 = start, bit1 = abort, bit2 = clear sticky bits. Write-1 pulses, never stored.
  - status (addr 9) read: {13'b0, lock_err, done_sticky, busy}.
  - addr 10 read: out_cnt. Unmapped reads return 0.
- FSM states IDLE, RUN, DRAIN, FINISH.
  - IDLE -> RUN on start: in_cnt, out_cnt cleared; done_sticky cleared.
  - RUN:
    - src_ready = src_valid & (in_cnt < FRAME_LEN), combinational.
    - On accept: fb_data <= src_data; fb_data_read <= 1 next cycle; in_cnt++.
    - Back-to-back accepts allowed; fb_data_read is high for exactly one cycle per sample.
    - RUN -> DRAIN on the edge where in_cnt reaches FRAME_LEN.
  - DRAIN: src_ready 0. DRAIN -> FINISH when out_cnt == FRAME_LEN/2.
  - FINISH: done = 1 for one cycle; done_sticky set; -> IDLE.
- Output path:
  - In RUN or DRAIN, each fb_ready pulse gives out_valid <= 1 and out_data <= fb_dout next cycle, then out_cnt++.
  - Pulses beyond FRAME_LEN/2, or arriving in IDLE/FINISH, are ignored.
- Start while busy: ignored, no error.
- Abort in any state: -> IDLE next edge; counters keep their values for readback; no done.
- Abort and start in the same write: abort wins.
- fb_ready in the same cycle as the final accept: counted normally.
- Reset asserted mid-frame: immediate return to reset values, coefficients included.
- Counter widths: in_cnt and out_cnt are clog2(FRAME_LEN)+1 bits; no wrap.

Optional Feature:
- Macro XB_CTRL_TIMEOUT_EN.
- Defined:
  - A DRAIN cycle counter runs. If out_cnt has not reached FRAME_LEN/2 after DRAIN_TIMEOUT cycles, go to FINISH anyway, with done pulse and sticky bit timeout_err (status bit 3).
  - The counter restarts on each fb_ready pulse.
- Undefined: DRAIN waits indefinitely; status bit 3 reads 0.

Test Plan:
- Reset, write coef0..7 = 0x0001..0x0008, read back -> values match; status = 0.
- FRAME_LEN=8, start, src_valid held high with data 1..8, bank model pulses fb_ready after every 2nd sample with fb_dout = 0x0100+n:
  - exactly 8 fb_data_read pulses, fb_data 1..8.
  - 4 out_valid pulses, out_data 0x0100..0x0103.
  - done one cycle after the 4th output; addr 10 reads 4.
- Write coef3 during RUN -> coef3 unchanged; lock_err = 1; clear via ctrl bit2 -> 0.
- src_valid toggling 1,0,1,... -> no fb_data_read during gaps; frame still completes with 8 strobes; extra src_valid after 8th sample -> src_ready stays 0.
- Abort mid-RUN after 3 samples -> busy 0 next cycle, no done, in_cnt frozen; new start re-runs a full frame correctly.
- With XB_CTRL_TIMEOUT_EN, DRAIN_TIMEOUT=32, bank returns only 3 of 4 outputs -> done 32 cycles after the last fb_ready; status bit3 = 1.
